// File: rtl/mac_arbiter.sv
// Round-robin arbiter that shares one MAC among N_REQ requesters.
// Quantizes the 16-bit result to 8 bits and returns it tagged with the requester id.
module mac_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [24*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   gnt,
  output logic               rsp_valid,
  output logic [2:0]         rsp_id,
  output logic [7:0]         rsp_data,
  output logic               rsp_err,
  output logic               busy,
  output logic               mac_en,
  output logic [7:0]         mac_a,
  output logic [7:0]         mac_b,
  output logic [7:0]         mac_c,
  input  logic [15:0]        mac_mout,
  input  logic               mac_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_RESP
  } state_e;

  state_e state_q, state_d;

  logic [2:0]       ptr_q, ptr_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [2:0]       rsp_id_q, rsp_id_d;
  logic [7:0]       rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic             mac_en_q, mac_en_d;
  logic [7:0]       mac_a_q, mac_a_d;
  logic [7:0]       mac_b_q, mac_b_d;
  logic [7:0]       mac_c_q, mac_c_d;

  logic             arb_hit;
  logic [2:0]       arb_idx;
  logic [23:0]      arb_ops;

  function automatic logic [7:0] quant(input logic [15:0] m);
    logic [7:0] r;
    r[7] = m[15];
    if (m[14] | m[13]) r[6:0] = 7'h7F;
    else               r[6:0] = m[12:6];
    return r;
  endfunction

  // Search starts one past the last grant so every requester gets a turn.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = ptr_q;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!arb_hit && req[(int'(ptr_q) + k) % N_REQ]) begin
        arb_hit = 1'b1;
        arb_idx = 3'((int'(ptr_q) + k) % N_REQ);
      end
    end
  end

  assign arb_ops = req_data[24*int'(arb_idx) +: 24];

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    gnt_d       = '0;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    mac_en_d    = mac_en_q;
    mac_a_d     = mac_a_q;
    mac_b_d     = mac_b_q;
    mac_c_d     = mac_c_q;
    unique case (state_q)
      S_IDLE: begin
        if (arb_hit) begin
          state_d  = S_RUN;
          ptr_d    = arb_idx;
          cnt_d    = '0;
          gnt_d    = N_REQ'(1) << arb_idx;
          rsp_id_d = arb_idx;
          mac_en_d = 1'b1;
          mac_a_d  = arb_ops[7:0];
          mac_b_d  = arb_ops[15:8];
          mac_c_d  = arb_ops[23:16];
        end
      end
      S_RUN: begin
        // A done arriving on the timeout cycle still counts as success.
        if (mac_done) begin
          state_d     = S_RESP;
          mac_en_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = quant(mac_mout);
          rsp_err_d   = 1'b0;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          state_d     = S_RESP;
          mac_en_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= 3'(N_REQ - 1);
      cnt_q       <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      mac_en_q    <= 1'b0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      mac_c_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      mac_en_q    <= mac_en_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      mac_c_q     <= mac_c_d;
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != S_IDLE);
  assign mac_en    = mac_en_q;
  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign mac_c     = mac_c_q;

endmodule

// File: tb/tb_mac_arbiter.sv
// Directed bench for mac_arbiter: vector table plus hand-written corner sequences.
// A small MAC model answers after a programmable latency (0 = never).
module tb_mac_arbiter;
  localparam int N  = 4;
  localparam int TO = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [24*N-1:0] req_data;
  logic [N-1:0]   gnt;
  logic           rsp_valid;
  logic [2:0]     rsp_id;
  logic [7:0]     rsp_data;
  logic           rsp_err;
  logic           busy;
  logic           mac_en;
  logic [7:0]     mac_a, mac_b, mac_c;
  logic [15:0]    mac_mout;
  logic           mac_done;

  mac_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .mac_en(mac_en), .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c),
    .mac_mout(mac_mout), .mac_done(mac_done)
  );

  always #5 clk = ~clk;

  int n_run = 0;
  int n_fail = 0;

  int          mlat;
  logic [15:0] mval;
  int          mcnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mac_done <= 1'b0;
      mac_mout <= '0;
      mcnt     <= 0;
    end else if (mac_en && !mac_done) begin
      if (mlat != 0 && mcnt == mlat - 1) begin
        mac_done <= 1'b1;
        mac_mout <= mval;
      end else begin
        mcnt <= mcnt + 1;
      end
    end else begin
      mac_done <= 1'b0;
      mcnt     <= 0;
    end
  end

  logic [23:0] sl [N];

  typedef struct {
    logic [N-1:0] req;
    int           lat;
    logic [15:0]  mout;
    int           id;
    logic [7:0]   data;
  } vec_t;

  vec_t tv [8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_gnt(output logic [N-1:0] g, output int idle);
    g = '0;
    idle = 0;
    for (int i = 0; i < 40 && g == '0; i++) begin
      @(negedge clk);
      g = gnt;
      if (g == '0 && !mac_en) idle++;
    end
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!rsp_valid && cyc < 40);
  endtask

  task automatic txn(input string nm, input logic [N-1:0] r, input int lat,
                     input logic [15:0] v, input int id, input logic [7:0] d,
                     input logic e, input int cyc_exp);
    logic [N-1:0] g;
    int idle, cyc;
    mlat = lat;
    mval = v;
    req  = r;
    wait_gnt(g, idle);
    chk({nm, " gnt"}, 32'(g), 32'(1 << id));
    chk({nm, " mac_en"}, 32'(mac_en), 32'd1);
    chk({nm, " ops"}, {8'h0, mac_c, mac_b, mac_a}, {8'h0, sl[id]});
    req = '0;
    @(negedge clk);
    chk({nm, " gnt pulse"}, 32'(gnt), 32'd0);
    wait_rsp(cyc);
    cyc++;
    chk({nm, " valid"}, 32'(rsp_valid), 32'd1);
    chk({nm, " id"}, 32'(rsp_id), 32'(id));
    chk({nm, " data"}, 32'(rsp_data), 32'(d));
    chk({nm, " err"}, 32'(rsp_err), 32'(e));
    if (cyc_exp != 0) chk({nm, " latency"}, 32'(cyc), 32'(cyc_exp));
    @(negedge clk);
    chk({nm, " valid pulse"}, 32'(rsp_valid), 32'd0);
    chk({nm, " mac_en off"}, 32'(mac_en), 32'd0);
    chk({nm, " hold"}, {rsp_err, rsp_id, rsp_data}, {e, 3'(id), d});
  endtask

  initial begin
    logic [N-1:0] g;
    int idle, cyc;

    sl[0] = 24'h0C0B0A;
    sl[1] = 24'h1C1B1A;
    sl[2] = 24'h030201;
    sl[3] = 24'h3C3B3A;
    req_data = {sl[3], sl[2], sl[1], sl[0]};

    tv[0] = '{4'b0001, 3, 16'h2000, 0, 8'h7F};
    tv[1] = '{4'b0010, 3, 16'h8040, 1, 8'h81};
    tv[2] = '{4'b1000, 3, 16'hE000, 3, 8'hFF};
    tv[3] = '{4'b0100, 2, 16'h1FC0, 2, 8'h7F};
    tv[4] = '{4'b1001, 3, 16'h003F, 3, 8'h00};
    tv[5] = '{4'b1001, 1, 16'h0FFF, 0, 8'h3F};
    tv[6] = '{4'b1001, 3, 16'h4000, 3, 8'h7F};
    tv[7] = '{4'b0110, 3, 16'hC0C0, 1, 8'hFF};

    rst  = 1'b1;
    req  = '0;
    mlat = 0;
    mval = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset outs",
        {gnt, rsp_valid, rsp_id, rsp_err, busy, mac_en},
        32'd0);
    chk("reset data", {rsp_data, mac_a, mac_b, mac_c}, 32'd0);

    // Rotation with all requesters held, twice.
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      if (k == 4) req = 4'b1111;
      mlat = 3;
      mval = 16'h0140;
      wait_gnt(g, idle);
      chk("rr gnt", 32'(g), 32'(1 << (k % 4)));
      if (k != 0) chk("rr gap", 32'(idle + 1 >= 2), 32'd1);
      req = req & ~g;
      wait_rsp(cyc);
      chk("rr id", 32'(rsp_id), 32'(k % 4));
      chk("rr mac_en low", 32'(mac_en), 32'd0);
    end
    @(negedge clk);

    txn("single", 4'b0100, 3, 16'h0140, 2, 8'h05, 1'b0, 4);

    for (int i = 0; i < 8; i++)
      txn($sformatf("vec%0d", i), tv[i].req, tv[i].lat, tv[i].mout,
          tv[i].id, tv[i].data, 1'b0, tv[i].lat + 1);

    txn("timeout", 4'b0001, 0, 16'h1234, 0, 8'h00, 1'b1, TO);
    txn("after to", 4'b0010, 3, 16'h0140, 1, 8'h05, 1'b0, 4);
    txn("done+to", 4'b0100, TO - 1, 16'h0140, 2, 8'h05, 1'b0, TO);

    // Reset while a transaction is in flight.
    mlat = 0;
    req  = 4'b1000;
    wait_gnt(g, idle);
    chk("mid gnt", 32'(g), 32'b1000);
    req = '0;
    repeat (2) @(negedge clk);
    chk("mid busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst outs",
        {gnt, rsp_valid, rsp_id, rsp_err, busy, mac_en},
        32'd0);
    chk("rst data", {rsp_data, mac_a, mac_b, mac_c}, 32'd0);
    cyc = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) cyc++;
    end
    rst = 1'b0;
    @(negedge clk);
    if (rsp_valid) cyc++;
    chk("rst no rsp", 32'(cyc), 32'd0);
    txn("post rst", 4'b0110, 3, 16'h0140, 1, 8'h05, 1'b0, 4);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mac_arbiter.md
# mac_arbiter

- Round-robin arbiter that shares one MAC unit (A_BITWIDTH=8, OUT_BITWIDTH=16) among N_REQ requesters.
- Each granted request drives the MAC with `mac_en` until `mac_done` or a timeout.
- Quantizes the 16-bit MAC output to 8 bits and returns it with the requester ID.
- Sits between compute clients, such as BRAM-fed controllers, and the single shared MAC instance.

## Interface

Parameters:
- N_REQ, 4, number of requesters (2..8)
- TIMEOUT, 255, max cycles in RUN waiting for `mac_done` before error (1..255)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  N_REQ  per-requester request; held with operands until its `gnt` bit pulses
- req_data  in  24*N_REQ  per-requester operands; slice i is {c[7:0], b[7:0], a[7:0]} at bits [24i+23:24i]
- gnt  out  N_REQ  one-hot, one-cycle pulse: request accepted, operands latched
- rsp_valid  out  1  one-cycle pulse: response available
- rsp_id  out  3  index of the requester being answered; valid with `rsp_valid`
- rsp_data  out  8  quantized result
- rsp_err  out  1  timeout flag; valid with `rsp_valid`
- busy  out  1  high in every state except IDLE
- mac_en  out  1  MAC enable
- mac_a / mac_b / mac_c  out  8 each  MAC operands, registered
- mac_mout  in  16  MAC result
- mac_done  in  1  MAC completion

## Operation

- States and transitions:
  - IDLE: if `req` is non-zero, go to RUN. Else stay.
  - RUN: on `mac_done`, go to RESP. On timeout, go to RESP with error. Else stay.
  - RESP: one cycle, then go to IDLE.
- Arbitration:
  - Search starts at `ptr+1`, wraps modulo N_REQ, and picks the first set `req` bit.
  - `ptr` updates to the granted index.
  - `ptr` resets to N_REQ-1, so requester 0 has first priority.
- Grant (IDLE→RUN transition edge):
  - `gnt[i]` goes high.
  - `mac_a`/`mac_b`/`mac_c` load from slice i.
  - `mac_en` goes high.
  - `rsp_id` register loads i.
  - Wait counter clears to 0.
- RUN:
  - `gnt` is 0 and `mac_en` holds 1.
  - Counter increments each cycle `mac_done` is low.
  - `req` is ignored in RUN and RESP.
- Completion (`mac_done` sampled high):
  - `mac_en` goes low.
  - `rsp_data` gets the quantized `mac_mout`.
  - `rsp_err` goes low.
  - `rsp_valid` goes high.
- Quantization:
  - `rsp_data[7]` = `mout[15]`.
  - If `mout[14]|mout[13]`, then `rsp_data[6:0]` = 7'h7F. Otherwise `rsp_data[6:0]` = `mout[12:6]`.
  - No rounding.
- Timeout (counter reaches TIMEOUT while `mac_done` is low):
  - `mac_en` goes low.
  - `rsp_data` goes to 0.
  - `rsp_err` goes high.
  - `rsp_valid` goes high.
  - `ptr` still advances; the requester is not retried.
- `mac_done` and timeout in the same cycle: `mac_done` wins, so `rsp_err` stays 0.
- `rsp_data`, `rsp_id` and `rsp_err` hold their values after the `rsp_valid` pulse until the next response.

## Timing

- Reset values: `gnt`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `rsp_err`=0, `busy`=0, `mac_en`=0, MAC operands=0, `ptr`=N_REQ-1, state IDLE.
- `req` high in IDLE at edge T → `gnt` and `mac_en` high after edge T.
- `mac_done` sampled at edge D → `rsp_valid` high after D, `mac_en` low after D.
- State is IDLE again after D+1.
- Earliest next grant: after edge D+2.
  - This guarantees at least two cycles of `mac_en`=0 between transactions, so the MAC clears DONE.
- Back-to-back requests from all N_REQ requesters are served in rotation; no requester waits more than N_REQ-1 other transactions.
- `req` dropped before it is sampled in IDLE: no grant, no response.
- Reset asserted mid-RUN: all outputs clear immediately (asynchronous). The in-flight transaction is discarded with no response. After reset release, arbitration restarts with requester 0.

## Test plan

- Single request: N_REQ=4, `req`=4'b0100, slice 2 = {c=8'h03, b=8'h02, a=8'h01}; MAC model has latency 3 and returns 16'h0140 → `gnt`=4'b0100 one cycle, `mac_a`/`mac_b`/`mac_c`=01/02/03 while `mac_en`=1, `rsp_valid` pulse with `rsp_id`=2, `rsp_data`=8'h05, `rsp_err`=0.
- Saturation and sign: MAC returns 16'h2000 → `rsp_data`=8'h7F. MAC returns 16'h8040 → `rsp_data`=8'h81. MAC returns 16'hE000 → `rsp_data`=8'hFF.
- Round robin: `req`=4'b1111 held and each requester drops its bit on its grant → grant order 0,1,2,3. Reassert all four → order 0,1,2,3 again. With only `req`=4'b1001 after granting 0 → next grant is 3.
- Timeout: TIMEOUT=8 and `mac_done` never asserts → `rsp_valid` pulse 8 cycles after grant, with `rsp_err`=1, `rsp_data`=0, `mac_en` low after the pulse. A following request is served normally.
- Simultaneous `mac_done` and timeout on the same cycle → `rsp_err`=0 with the valid quantized data. Also check that at least two cycles with `mac_en`=0 separate consecutive grants.
- Reset mid-RUN: assert `rst` two cycles after grant → all outputs 0 within the same cycle and no `rsp_valid`. After release, with `req`=4'b0110 → first grant is requester 1.
